// File: rtl/csr_commit_ctrl.sv
// Writeback-stage CSR commit controller: drives the CSR bus, flush strobes and front-end redirect.
// Optional privilege check on CSR/ERTN ops is enabled by defining CSR_PRIV_CHECK_EN.
module csr_commit_ctrl #(
  parameter int          FLUSH_CYCLES = 2,
  parameter logic [31:0] PC_RESET     = 32'h1c000000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_op,
  input  logic [13:0] in_csr_num,
  input  logic [31:0] in_rd_val,
  input  logic [31:0] in_rj_val,
  input  logic [4:0]  in_rd,
  input  logic [31:0] in_pc,
  input  logic [1:0]  plv_in,
  input  logic        has_int,
  input  logic [31:0] eentry,
  input  logic [31:0] era,
  output logic [13:0] csr_raddr,
  input  logic [31:0] csr_rdata,
  output logic        csr_wr_en,
  output logic [13:0] csr_waddr,
  output logic [31:0] csr_wdata,
  output logic        excp_flush,
  output logic        ertn_flush,
  output logic [31:0] era_in,
  output logic [5:0]  ecode_in,
  output logic [8:0]  esubcode_in,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  localparam logic [2:0] OP_CSRRD   = 3'd1;
  localparam logic [2:0] OP_CSRWR   = 3'd2;
  localparam logic [2:0] OP_CSRXCHG = 3'd3;
  localparam logic [2:0] OP_ERTN    = 3'd4;
  localparam logic [2:0] OP_SYSCALL = 3'd5;
  localparam logic [2:0] OP_BREAK   = 3'd6;
  localparam logic [2:0] OP_INE     = 3'd7;

`ifdef CSR_PRIV_CHECK_EN
  localparam bit PRIV_CHK = 1'b1;
`else
  localparam bit PRIV_CHK = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    FLUSH  = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;

  logic fire;
  logic is_exc_op;
  logic priv_op;
  logic priv_fault;
  logic take_excp;
  logic exec;
  logic take_ertn;
  logic do_write;
  logic do_read;

  assign in_ready  = (state == IDLE);
  assign fire      = in_valid & in_ready;
  assign csr_raddr = in_csr_num;

  assign is_exc_op  = (in_op == OP_SYSCALL) | (in_op == OP_BREAK) | (in_op == OP_INE);
  assign priv_op    = (in_op == OP_CSRRD) | (in_op == OP_CSRWR) |
                      (in_op == OP_CSRXCHG) | (in_op == OP_ERTN);
  assign priv_fault = PRIV_CHK & priv_op & (plv_in != 2'd0);

  // Interrupt wins over everything; the presented instruction is then discarded.
  assign take_excp = fire & (has_int | is_exc_op | priv_fault);
  assign exec      = fire & ~take_excp;
  assign take_ertn = exec & (in_op == OP_ERTN);
  assign do_write  = exec & ((in_op == OP_CSRWR) | (in_op == OP_CSRXCHG));
  assign do_read   = exec & ((in_op == OP_CSRRD) | (in_op == OP_CSRWR) | (in_op == OP_CSRXCHG));

  always_comb begin
    excp_flush  = take_excp;
    ertn_flush  = take_ertn;
    csr_wr_en   = do_write;
    csr_waddr   = 14'd0;
    csr_wdata   = 32'd0;
    era_in      = 32'd0;
    ecode_in    = 6'd0;
    esubcode_in = 9'd0;
    if (do_write) begin
      csr_waddr = in_csr_num;
      if (in_op == OP_CSRXCHG)
        csr_wdata = (in_rd_val & in_rj_val) | (csr_rdata & ~in_rj_val);
      else
        csr_wdata = in_rd_val;
    end
    if (take_excp) begin
      era_in = in_pc;
      if (has_int)
        ecode_in = 6'h00;
      else if (priv_fault)
        ecode_in = 6'h0E;
      else begin
        case (in_op)
          OP_SYSCALL: ecode_in = 6'h0B;
          OP_BREAK:   ecode_in = 6'h0C;
          default:    ecode_in = 6'h0D;
        endcase
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (take_excp | take_ertn) begin
          state_nxt = FLUSH;
          cnt_nxt   = 4'(FLUSH_CYCLES - 1);
        end else if (do_write) begin
          state_nxt = SETTLE;
        end
      end
      SETTLE: state_nxt = IDLE;
      FLUSH: begin
        if (cnt == 4'd0)
          state_nxt = IDLE;
        else
          cnt_nxt = cnt - 4'd1;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // GPR writeback returns the CSR value as read before any write in the same fire.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rf_we          <= 1'b0;
      rf_waddr       <= 5'd0;
      rf_wdata       <= 32'd0;
      redirect_valid <= 1'b0;
      redirect_pc    <= PC_RESET;
    end else begin
      rf_we          <= do_read & (in_rd != 5'd0);
      redirect_valid <= take_excp | take_ertn;
      if (do_read) begin
        rf_waddr <= in_rd;
        rf_wdata <= csr_rdata;
      end
      if (take_excp)
        redirect_pc <= eentry;
      else if (take_ertn)
        redirect_pc <= era;
    end
  end

endmodule

// File: tb/tb_csr_commit_ctrl.sv
// Randomized and directed bench for csr_commit_ctrl against a cycle-level reference model.
module tb_csr_commit_ctrl;
  localparam int          FC  = 2;
  localparam logic [31:0] PCR = 32'h1c000000;

  logic        clk, resetn;
  logic        in_valid, in_ready;
  logic [2:0]  in_op;
  logic [13:0] in_csr_num;
  logic [31:0] in_rd_val, in_rj_val, in_pc, eentry, era, csr_rdata;
  logic [4:0]  in_rd;
  logic [1:0]  plv_in;
  logic        has_int;
  logic [13:0] csr_raddr, csr_waddr;
  logic        csr_wr_en, excp_flush, ertn_flush, rf_we, redirect_valid;
  logic [31:0] csr_wdata, era_in, rf_wdata, redirect_pc;
  logic [5:0]  ecode_in;
  logic [8:0]  esubcode_in;
  logic [4:0]  rf_waddr;

  int vecs = 0;
  int errs = 0;

  csr_commit_ctrl #(.FLUSH_CYCLES(FC), .PC_RESET(PCR)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_csr_num(in_csr_num), .in_rd_val(in_rd_val), .in_rj_val(in_rj_val),
    .in_rd(in_rd), .in_pc(in_pc), .plv_in(plv_in), .has_int(has_int), .eentry(eentry),
    .era(era), .csr_raddr(csr_raddr), .csr_rdata(csr_rdata), .csr_wr_en(csr_wr_en),
    .csr_waddr(csr_waddr), .csr_wdata(csr_wdata), .excp_flush(excp_flush),
    .ertn_flush(ertn_flush), .era_in(era_in), .ecode_in(ecode_in), .esubcode_in(esubcode_in),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef CSR_PRIV_CHECK_EN
  localparam bit PRIV = 1'b1;
`else
  localparam bit PRIV = 1'b0;
`endif

  task automatic drive(input logic v, input logic [2:0] op, input logic [13:0] num,
                       input logic [31:0] rdv, input logic [31:0] rjv, input logic [4:0] rd,
                       input logic [31:0] pc, input logic [1:0] plv, input logic hi,
                       input logic [31:0] ee, input logic [31:0] er, input logic [31:0] rdata);
    in_valid = v; in_op = op; in_csr_num = num; in_rd_val = rdv; in_rj_val = rjv;
    in_rd = rd; in_pc = pc; plv_in = plv; has_int = hi; eentry = ee; era = er;
    csr_rdata = rdata;
  endtask

  task automatic idle_inputs();
    drive(1'b0, 3'd0, 14'd0, 32'd0, 32'd0, 5'd0, 32'd0, 2'd0, 1'b0, 32'd0, 32'd0, 32'd0);
  endtask

  // Reset asserted and released #1 after a rising edge; leaves time at post-release +1.
  task automatic apply_reset();
    idle_inputs();
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    vecs++; if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'd0) begin
      errs++; $display("FAIL reset_rf got we=%b a=%h d=%h exp 0/0/0", rf_we, rf_waddr, rf_wdata); end
    vecs++; if (redirect_valid !== 1'b0 || redirect_pc !== PCR) begin
      errs++; $display("FAIL reset_redirect got v=%b pc=%h exp 0/%h", redirect_valid, redirect_pc, PCR); end
  endtask

  task automatic test_csrxchg();
    @(posedge clk); #1;
    drive(1'b1, 3'd3, 14'h30, 32'h12345678, 32'hFFFF0000, 5'd7, 32'h1c000040, 2'd0, 1'b0,
          32'h1c008000, 32'd0, 32'hAAAA5555);
    #1;
    vecs++; if (csr_wr_en !== 1'b1 || csr_wdata !== 32'h12345555 || csr_waddr !== 14'h30) begin
      errs++; $display("FAIL xchg_bus got en=%b a=%h d=%h exp 1/0030/12345555", csr_wr_en, csr_waddr, csr_wdata); end
    @(posedge clk); #1; idle_inputs(); #1;
    vecs++; if (rf_we !== 1'b1 || rf_wdata !== 32'hAAAA5555 || rf_waddr !== 5'd7) begin
      errs++; $display("FAIL xchg_rf got we=%b a=%0d d=%h exp 1/7/aaaa5555", rf_we, rf_waddr, rf_wdata); end
    vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL xchg_settle got=%b exp=0", in_ready); end
    @(posedge clk); #2;
    vecs++; if (in_ready !== 1'b1 || rf_we !== 1'b0) begin
      errs++; $display("FAIL xchg_after got rdy=%b we=%b exp 1/0", in_ready, rf_we); end
  endtask

  task automatic test_syscall();
    @(posedge clk); #1;
    drive(1'b1, 3'd5, 14'h0, 32'd0, 32'd0, 5'd3, 32'h1c000100, 2'd0, 1'b0,
          32'h1c008000, 32'd0, 32'h0);
    #1;
    vecs++; if (excp_flush !== 1'b1 || ecode_in !== 6'h0B || era_in !== 32'h1c000100 ||
                esubcode_in !== 9'd0 || ertn_flush !== 1'b0 || csr_wr_en !== 1'b0) begin
      errs++; $display("FAIL syscall_bus got ex=%b ec=%h era=%h sub=%h er=%b we=%b",
                       excp_flush, ecode_in, era_in, esubcode_in, ertn_flush, csr_wr_en); end
    @(posedge clk); #1; idle_inputs(); in_valid = 1'b1; #1;
    vecs++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h1c008000 || rf_we !== 1'b0) begin
      errs++; $display("FAIL syscall_redirect got v=%b pc=%h we=%b exp 1/1c008000/0", redirect_valid, redirect_pc, rf_we); end
    for (int i = 0; i < FC; i++) begin
      vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL syscall_stall%0d got=%b exp=0", i, in_ready); end
      if (i < FC - 1) begin @(posedge clk); #2; end
    end
    @(posedge clk); #2;
    vecs++; if (in_ready !== 1'b1 || redirect_valid !== 1'b0) begin
      errs++; $display("FAIL syscall_release got rdy=%b v=%b exp 1/0", in_ready, redirect_valid); end
    @(posedge clk); #1; idle_inputs(); #1;
  endtask

  task automatic test_int_csrwr();
    @(posedge clk); #1;
    drive(1'b1, 3'd2, 14'h4, 32'hDEADBEEF, 32'd0, 5'd9, 32'h1c000200, 2'd0, 1'b1,
          32'h1c00c000, 32'd0, 32'h11111111);
    #1;
    vecs++; if (csr_wr_en !== 1'b0 || excp_flush !== 1'b1 || ecode_in !== 6'h00 || era_in !== 32'h1c000200) begin
      errs++; $display("FAIL int_bus got we=%b ex=%b ec=%h era=%h exp 0/1/00/1c000200", csr_wr_en, excp_flush, ecode_in, era_in); end
    @(posedge clk); #1; idle_inputs(); #1;
    vecs++; if (rf_we !== 1'b0 || redirect_pc !== 32'h1c00c000) begin
      errs++; $display("FAIL int_rf got we=%b pc=%h exp 0/1c00c000", rf_we, redirect_pc); end
    repeat (FC) @(posedge clk); #2;
  endtask

  task automatic test_ertn();
    @(posedge clk); #1;
    drive(1'b1, 3'd4, 14'h6, 32'd0, 32'd0, 5'd0, 32'h1c000300, 2'd0, 1'b0,
          32'h1c008000, 32'h1c000204, 32'd0);
    #1;
    vecs++; if (ertn_flush !== 1'b1 || excp_flush !== 1'b0 || csr_wr_en !== 1'b0) begin
      errs++; $display("FAIL ertn_bus got er=%b ex=%b we=%b exp 1/0/0", ertn_flush, excp_flush, csr_wr_en); end
    @(posedge clk); #1; idle_inputs(); #1;
    vecs++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h1c000204) begin
      errs++; $display("FAIL ertn_redirect got v=%b pc=%h exp 1/1c000204", redirect_valid, redirect_pc); end
    repeat (FC) @(posedge clk); #2;
  endtask

  task automatic test_reset_mid_flush();
    @(posedge clk); #1;
    drive(1'b1, 3'd6, 14'h0, 32'd0, 32'd0, 5'd0, 32'h1c000400, 2'd0, 1'b0,
          32'h1c00f000, 32'd0, 32'd0);
    @(posedge clk); #1; idle_inputs(); in_valid = 1'b1;
    resetn = 1'b0; #1;
    vecs++; if (redirect_valid !== 1'b0 || redirect_pc !== PCR) begin
      errs++; $display("FAIL midflush_reset got v=%b pc=%h exp 0/%h", redirect_valid, redirect_pc, PCR); end
    @(posedge clk); #1; resetn = 1'b1; in_valid = 1'b0; #1;
    vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL midflush_release got=%b exp=1", in_ready); end
    repeat (3) begin
      @(posedge clk); #2;
      vecs++; if (redirect_valid !== 1'b0 || in_ready !== 1'b1) begin
        errs++; $display("FAIL midflush_quiet got v=%b rdy=%b exp 0/1", redirect_valid, in_ready); end
    end
  endtask

  task automatic test_priv();
    @(posedge clk); #1;
    drive(1'b1, 3'd1, 14'h1, 32'd0, 32'd0, 5'd5, 32'h1c000500, 2'd3, 1'b0,
          32'h1c008800, 32'd0, 32'hCAFEF00D);
    #1;
    vecs++; if (excp_flush !== PRIV || ecode_in !== (PRIV ? 6'h0E : 6'h00) || csr_wr_en !== 1'b0) begin
      errs++; $display("FAIL priv_bus got ex=%b ec=%h exp %b/%h", excp_flush, ecode_in, PRIV, PRIV ? 6'h0E : 6'h00); end
    @(posedge clk); #1; idle_inputs(); #1;
    vecs++; if (rf_we !== !PRIV || (!PRIV && rf_wdata !== 32'hCAFEF00D)) begin
      errs++; $display("FAIL priv_rf got we=%b d=%h exp we=%b", rf_we, rf_wdata, !PRIV); end
    repeat (FC) @(posedge clk); #2;
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals [3];
    vals[0] = 32'h01020304; vals[1] = 32'hF0E0D0C0; vals[2] = 32'h5A5A5A5A;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      drive(1'b1, 3'd1, 14'(i + 16), 32'd0, 32'd0, 5'(i + 1), 32'h1c000600, 2'd0, 1'b0,
            32'd0, 32'd0, vals[i]);
      #1;
      vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL b2b_ready%0d got=%b exp=1", i, in_ready); end
      if (i > 0) begin
        vecs++; if (rf_we !== 1'b1 || rf_wdata !== vals[i-1] || rf_waddr !== 5'(i)) begin
          errs++; $display("FAIL b2b_rf%0d got we=%b a=%0d d=%h exp 1/%0d/%h", i, rf_we, rf_waddr, rf_wdata, i, vals[i-1]); end
      end
    end
    @(posedge clk); #1; idle_inputs(); #1;
    vecs++; if (rf_we !== 1'b1 || rf_wdata !== vals[2]) begin
      errs++; $display("FAIL b2b_last got we=%b d=%h exp 1/%h", rf_we, rf_wdata, vals[2]); end
  endtask

  // Reference model: a stall countdown plus the last expected registered outputs.
  task automatic test_random();
    int          stall;
    logic        m_we, m_rv;
    logic [4:0]  m_wa;
    logic [31:0] m_wd, m_pc;
    logic        f, intr, priv_bad, exc, ert, wr, rd_op;
    logic [5:0]  ec;
    logic [31:0] wd;
    apply_reset();
    stall = 0; m_we = 0; m_rv = 0; m_wa = 0; m_wd = 0; m_pc = PCR;
    for (int n = 0; n < 600; n++) begin
      @(posedge clk); #1;
      vecs++; if (in_ready !== (stall == 0)) begin
        errs++; $display("FAIL rnd_ready c%0d got=%b exp=%b", n, in_ready, stall == 0); end
      vecs++; if (rf_we !== m_we || (m_we && (rf_waddr !== m_wa || rf_wdata !== m_wd))) begin
        errs++; $display("FAIL rnd_rf c%0d got we=%b a=%0d d=%h exp %b/%0d/%h", n, rf_we, rf_waddr, rf_wdata, m_we, m_wa, m_wd); end
      vecs++; if (redirect_valid !== m_rv || redirect_pc !== m_pc) begin
        errs++; $display("FAIL rnd_redirect c%0d got v=%b pc=%h exp %b/%h", n, redirect_valid, redirect_pc, m_rv, m_pc); end
      drive(($urandom_range(0, 9) < 7), 3'($urandom_range(0, 7)), 14'($urandom), $urandom, $urandom,
            (($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom)), $urandom,
            (($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0),
            ($urandom_range(0, 7) == 0), $urandom, $urandom, $urandom);
      #1;
      f        = in_valid && (stall == 0);
      intr     = f && has_int;
      priv_bad = PRIV && (in_op >= 3'd1 && in_op <= 3'd4) && (plv_in != 2'd0);
      exc      = f && (has_int || in_op >= 3'd5 || priv_bad);
      ert      = f && !exc && in_op == 3'd4;
      wr       = f && !exc && (in_op == 3'd2 || in_op == 3'd3);
      rd_op    = f && !exc && (in_op >= 3'd1 && in_op <= 3'd3);
      ec = 6'h00;
      if (exc && !intr) ec = priv_bad ? 6'h0E : (in_op == 3'd5) ? 6'h0B : (in_op == 3'd6) ? 6'h0C : 6'h0D;
      wd = 32'd0;
      for (int b = 0; b < 32; b++)
        if (wr) wd[b] = (in_op == 3'd2 || in_rj_val[b]) ? in_rd_val[b] : csr_rdata[b];
      vecs++; if (excp_flush !== exc || ertn_flush !== ert || csr_wr_en !== wr) begin
        errs++; $display("FAIL rnd_strobes c%0d got ex=%b er=%b we=%b exp %b/%b/%b", n, excp_flush, ertn_flush, csr_wr_en, exc, ert, wr); end
      vecs++; if (csr_wdata !== wd || csr_waddr !== (wr ? in_csr_num : 14'd0) || csr_raddr !== in_csr_num) begin
        errs++; $display("FAIL rnd_csrbus c%0d got wa=%h wd=%h ra=%h exp wd=%h", n, csr_waddr, csr_wdata, csr_raddr, wd); end
      vecs++; if (ecode_in !== ec || era_in !== (exc ? in_pc : 32'd0) || esubcode_in !== 9'd0) begin
        errs++; $display("FAIL rnd_excp c%0d got ec=%h era=%h sub=%h exp %h/%h", n, ecode_in, era_in, esubcode_in, ec, exc ? in_pc : 32'd0); end
      m_we = rd_op && (in_rd != 5'd0);
      if (rd_op) begin m_wa = in_rd; m_wd = csr_rdata; end
      m_rv = exc || ert;
      if (exc) m_pc = eentry; else if (ert) m_pc = era;
      if (exc || ert) stall = FC;
      else if (wr) stall = 1;
      else if (stall > 0) stall--;
    end
    @(posedge clk); #1; idle_inputs();
  endtask

  initial begin
    resetn = 1'b1;
    idle_inputs();
    #2;
    test_reset();
    test_csrxchg();
    test_syscall();
    test_int_csrwr();
    test_ertn();
    test_priv();
    test_back_to_back();
    test_reset_mid_flush();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
